// File: rtl/vendo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vendo_pkg
//  Description : Shared definitions for the vending-machine buyer: state
//                encoding, item/coin codes, item prices and a small helper
//                for sizing counters.
//  Revision    : 1.0  initial release
// ============================================================================
package vendo_pkg;

  // State encoding (3 bits, seven states used)
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEL   = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_COIN  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_COUNT = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_SEL   = S_SEL,
    ST_GAP   = S_GAP,
    ST_COIN  = S_COIN,
    ST_WAIT  = S_WAIT,
    ST_COUNT = S_COUNT,
    ST_RESP  = S_RESP
  } state_t;

  // Item and coin codes
  localparam logic ITEM_A = 1'b0;
  localparam logic ITEM_B = 1'b1;
  localparam logic COIN_1 = 1'b0;
  localparam logic COIN_5 = 1'b1;

  // Item prices in pesos
  localparam int PRICE_A = 2;
  localparam int PRICE_B = 3;

  // Number of bits needed to hold values 0..max_count (at least 1).
  function automatic int tmr_width(input int max_count);
    if (max_count < 2) return 1;
    return $clog2(max_count + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vendo_buyer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vendo_buyer_if
//  Description : Bundles the host request/response channel and the vending
//                block pulse/observation signals of the buyer.
//  Ports       : req_*  - request from host (valid/ready handshake)
//                rsp_*  - one-cycle response strobe plus held result fields
//                sel_A/sel_B/p_1/p_5 - pulses towards the vending block
//                disp_A/disp_B/change - observations from the vending block
//  Modports    : slave  - the buyer itself
//                master - the host/vendor environment around the buyer
//  Revision    : 1.0  initial release
// ============================================================================
interface vendo_buyer_if #(
  parameter int CHG_W = 4
);
  // Host request
  logic             req_valid;
  logic             req_ready;
  logic             req_item;
  logic [1:0]       req_ncoins;
  logic [2:0]       req_coins;
  // Vendor side
  logic             sel_A;
  logic             sel_B;
  logic             p_1;
  logic             p_5;
  logic             disp_A;
  logic             disp_B;
  logic             change;
  // Host response
  logic             rsp_valid;
  logic             rsp_item_ok;
  logic             rsp_wrong_item;
  logic [CHG_W-1:0] rsp_change;
  logic [1:0]       rsp_coins_used;
  logic             rsp_timeout;

  modport slave (
    input  req_valid, req_item, req_ncoins, req_coins,
    input  disp_A, disp_B, change,
    output req_ready,
    output sel_A, sel_B, p_1, p_5,
    output rsp_valid, rsp_item_ok, rsp_wrong_item, rsp_change,
    output rsp_coins_used, rsp_timeout
  );

  modport master (
    output req_valid, req_item, req_ncoins, req_coins,
    output disp_A, disp_B, change,
    input  req_ready,
    input  sel_A, sel_B, p_1, p_5,
    input  rsp_valid, rsp_item_ok, rsp_wrong_item, rsp_change,
    input  rsp_coins_used, rsp_timeout
  );

endinterface
`default_nettype wire

// File: rtl/vendo_buyer_tmr.sv
`default_nettype none
// ============================================================================
//  Module      : vendo_buyer_tmr
//  Description : Loadable down-counter used for both the inter-pulse gap and
//                the vendor-response timeout. Load has priority over
//                decrement; the count stops at zero.
//  Ports       : clk, rst  - clock, asynchronous active-high reset
//                load      - load load_val this cycle
//                load_val  - value to load
//                dec       - decrement by one (ignored at zero)
//                zero      - count is zero
//  Revision    : 1.0  initial release
// ============================================================================
module vendo_buyer_tmr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/vendo_buyer.sv
`default_nettype none
// ============================================================================
//  Module      : vendo_buyer
//  Description : Transaction initiator for the vending FSM. Turns one host
//                request into a select pulse followed by up to three coin
//                pulses, watches the vendor dispense/change outputs and
//                returns one response per purchase.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - vendo_buyer_if.slave: request/response channel and
//                       vendor pulse/observation signals
//  Revision    : 1.0  initial release
// ============================================================================
module vendo_buyer
  import vendo_pkg::*;
#(
  parameter int GAP     = 1,
  parameter int TIMEOUT = 16,
  parameter int CHG_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  vendo_buyer_if.slave  bus
);

  localparam int TMR_W = tmr_width((GAP > TIMEOUT) ? GAP : TIMEOUT);
  // GAP state always lasts at least one cycle, so GAP = 0 and GAP = 1 both
  // advance on the next cycle.
  localparam logic [TMR_W-1:0] GAP_LD = (GAP > 0)     ? TMR_W'(GAP - 1)     : '0;
  localparam logic [TMR_W-1:0] TO_LD  = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  state_t           r_state, w_state_nxt;
  logic             r_item, w_item_nxt;
  logic [1:0]       r_ncoins, w_ncoins_nxt;
  logic [2:0]       r_coins, w_coins_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic             r_item_ok, w_item_ok_nxt;
  logic             r_wrong, w_wrong_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [CHG_W-1:0] r_chg, w_chg_nxt;
  logic             r_req_ready, w_req_ready_nxt;
  logic             r_sel_a, w_sel_a_nxt;
  logic             r_sel_b, w_sel_b_nxt;
  logic             r_p1, w_p1_nxt;
  logic             r_p5, w_p5_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;

  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_dec;
  logic             w_tmr_zero;

  logic             w_vend_act;
  logic             w_sample;
  logic             w_coin_is5;

  assign w_vend_act = bus.disp_A | bus.disp_B | bus.change;
  // Vendor outputs only matter while a purchase is waiting for them.
  assign w_sample   = (r_state == ST_GAP) || (r_state == ST_WAIT) ||
                      (r_state == ST_COUNT);
  // r_idx is only used here while r_idx < r_ncoins <= 3, so it stays in range.
  assign w_coin_is5 = (r_coins[r_idx] == COIN_5);

  vendo_buyer_tmr #(
    .W (TMR_W)
  ) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .dec      (w_tmr_dec),
    .zero     (w_tmr_zero)
  );

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_item      <= 1'b0;
      r_ncoins    <= '0;
      r_coins     <= '0;
      r_idx       <= '0;
      r_item_ok   <= 1'b0;
      r_wrong     <= 1'b0;
      r_timeout   <= 1'b0;
      r_chg       <= '0;
      r_req_ready <= 1'b1;
      r_sel_a     <= 1'b0;
      r_sel_b     <= 1'b0;
      r_p1        <= 1'b0;
      r_p5        <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_item      <= w_item_nxt;
      r_ncoins    <= w_ncoins_nxt;
      r_coins     <= w_coins_nxt;
      r_idx       <= w_idx_nxt;
      r_item_ok   <= w_item_ok_nxt;
      r_wrong     <= w_wrong_nxt;
      r_timeout   <= w_timeout_nxt;
      r_chg       <= w_chg_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_sel_a     <= w_sel_a_nxt;
      r_sel_b     <= w_sel_b_nxt;
      r_p1        <= w_p1_nxt;
      r_p5        <= w_p5_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. Pulse outputs are computed for the
  // state being entered, so each pulse is high exactly during that state.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_item_nxt      = r_item;
    w_ncoins_nxt    = r_ncoins;
    w_coins_nxt     = r_coins;
    w_idx_nxt       = r_idx;
    w_item_ok_nxt   = r_item_ok;
    w_wrong_nxt     = r_wrong;
    w_timeout_nxt   = r_timeout;
    w_chg_nxt       = r_chg;
    w_req_ready_nxt = 1'b0;
    w_sel_a_nxt     = 1'b0;
    w_sel_b_nxt     = 1'b0;
    w_p1_nxt        = 1'b0;
    w_p5_nxt        = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_tmr_load      = 1'b0;
    w_tmr_val       = GAP_LD;
    w_tmr_dec       = 1'b0;

    // Result accumulation runs in every sampling state, so a dispense seen
    // in GAP/WAIT (the cycle that triggers COUNT) is not lost.
    if (w_sample) begin
      if (bus.disp_A) begin
        if (r_item == ITEM_A) w_item_ok_nxt = 1'b1;
        else                  w_wrong_nxt   = 1'b1;
      end
      if (bus.disp_B) begin
        if (r_item == ITEM_B) w_item_ok_nxt = 1'b1;
        else                  w_wrong_nxt   = 1'b1;
      end
      if (bus.change && !(&r_chg)) begin
        w_chg_nxt = r_chg + 1'b1;
      end
    end

    case (r_state)
      ST_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (bus.req_valid) begin
          w_item_nxt      = bus.req_item;
          w_ncoins_nxt    = bus.req_ncoins;
          w_coins_nxt     = bus.req_coins;
          w_idx_nxt       = '0;
          w_item_ok_nxt   = 1'b0;
          w_wrong_nxt     = 1'b0;
          w_timeout_nxt   = 1'b0;
          w_chg_nxt       = '0;
          w_req_ready_nxt = 1'b0;
          w_sel_a_nxt     = (bus.req_item == ITEM_A);
          w_sel_b_nxt     = (bus.req_item == ITEM_B);
          w_state_nxt     = ST_SEL;
        end
      end

      ST_SEL: begin
        w_tmr_load  = 1'b1;
        w_tmr_val   = GAP_LD;
        w_state_nxt = ST_GAP;
      end

      ST_GAP: begin
        w_tmr_dec = 1'b1;
        if (w_vend_act) begin
          w_state_nxt = ST_COUNT;
        end else if (w_tmr_zero) begin
          if (r_idx < r_ncoins) begin
            w_p5_nxt    = w_coin_is5;
            w_p1_nxt    = !w_coin_is5;
            w_state_nxt = ST_COIN;
          end else begin
            w_tmr_load  = 1'b1;
            w_tmr_val   = TO_LD;
            w_state_nxt = ST_WAIT;
          end
        end
      end

      ST_COIN: begin
        w_idx_nxt   = r_idx + 1'b1;
        w_tmr_load  = 1'b1;
        w_tmr_val   = GAP_LD;
        w_state_nxt = ST_GAP;
      end

      ST_WAIT: begin
        w_tmr_dec = 1'b1;
        if (w_vend_act) begin
          w_state_nxt = ST_COUNT;
        end else if (w_tmr_zero) begin
          w_timeout_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end
      end

      ST_COUNT: begin
        if (!w_vend_act) begin
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end
      end

      ST_RESP: begin
        w_req_ready_nxt = 1'b1;
        w_state_nxt     = ST_IDLE;
      end

      default: begin
        w_req_ready_nxt = 1'b1;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. Result registers double as response fields: they hold from the
  // response until the next request is accepted.
  // --------------------------------------------------------------------------
  assign bus.req_ready      = r_req_ready;
  assign bus.sel_A          = r_sel_a;
  assign bus.sel_B          = r_sel_b;
  assign bus.p_1            = r_p1;
  assign bus.p_5            = r_p5;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_item_ok    = r_item_ok;
  assign bus.rsp_wrong_item = r_wrong;
  assign bus.rsp_change     = r_chg;
  assign bus.rsp_coins_used = r_idx;
  assign bus.rsp_timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_vendo_buyer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vendo_buyer
//  Description : Self-checking bench for vendo_buyer with a behavioural
//                vending-machine model and a response scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vendo_buyer;
  import vendo_pkg::*;

  localparam int GAP     = 1;
  localparam int TIMEOUT = 16;
  localparam int CHG_W   = 4;

  typedef struct packed {
    logic             item_ok;
    logic             wrong;
    logic [CHG_W-1:0] chg;
    logic [1:0]       used;
    logic             tmo;
  } rsp_t;

  typedef struct {
    bit   got;
    rsp_t rsp;
    rsp_t hold;
    logic rdy_busy;
    logic rdy_at_rsp;
    logic rdy_after;
    logic valid_after;
    int   sel_a, sel_b, p1, p5, multi, rsps, lat;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vendo_buyer_if #(.CHG_W(CHG_W)) bus ();

  vendo_buyer #(
    .GAP     (GAP),
    .TIMEOUT (TIMEOUT),
    .CHG_W   (CHG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  rsp_t exp_q[$];

  // ---------------- vending machine model ----------------
  bit   vendor_wrong = 1'b0;
  logic v_sel, v_item;
  int   v_credit, v_chg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      v_sel <= 1'b0; v_item <= 1'b0; v_credit <= 0; v_chg <= 0;
      bus.disp_A <= 1'b0; bus.disp_B <= 1'b0; bus.change <= 1'b0;
    end else begin
      bus.disp_A <= 1'b0; bus.disp_B <= 1'b0; bus.change <= 1'b0;
      if (bus.sel_A || bus.sel_B) begin
        v_sel <= 1'b1; v_item <= bus.sel_B; v_credit <= 0;
      end else if (bus.p_1 || bus.p_5) begin
        if (v_sel && (v_credit + (bus.p_5 ? 5 : 1)) >= (v_item ? PRICE_B : PRICE_A)) begin
          if (v_item ^ vendor_wrong) bus.disp_B <= 1'b1;
          else                       bus.disp_A <= 1'b1;
          v_chg    <= v_credit + (bus.p_5 ? 5 : 1) - (v_item ? PRICE_B : PRICE_A);
          v_credit <= 0;
          v_sel    <= 1'b0;
        end else begin
          v_credit <= v_credit + (bus.p_5 ? 5 : 1);
        end
      end else if (v_chg > 0) begin
        bus.change <= 1'b1;
        v_chg      <= v_chg - 1;
      end
    end
  end

  // ---------------- monitor (monotonic totals) ----------------
  int cyc = 0;
  int sel_a_tot = 0, sel_b_tot = 0, p1_tot = 0, p5_tot = 0;
  int multi_tot = 0, rsp_tot = 0, last_pulse_cyc = 0, rsp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.sel_A) sel_a_tot <= sel_a_tot + 1;
    if (bus.sel_B) sel_b_tot <= sel_b_tot + 1;
    if (bus.p_1)   p1_tot    <= p1_tot + 1;
    if (bus.p_5)   p5_tot    <= p5_tot + 1;
    if ($countones({bus.sel_A, bus.sel_B, bus.p_1, bus.p_5}) > 1) multi_tot <= multi_tot + 1;
    if (bus.sel_A || bus.sel_B || bus.p_1 || bus.p_5) last_pulse_cyc <= cyc;
    if (bus.rsp_valid) begin
      rsp_tot <= rsp_tot + 1;
      rsp_cyc <= cyc;
    end
  end

  // ---------------- reference model of one purchase ----------------
  function automatic rsp_t model(input logic item, input logic [1:0] n,
                                 input logic [2:0] coins, input bit wrong);
    rsp_t e;
    int   credit;
    int   price;
    bit   done;
    e = '0; credit = 0; done = 0;
    price  = (item == ITEM_B) ? PRICE_B : PRICE_A;
    e.used = n;
    e.tmo  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!done && i < int'(n)) begin
        credit += coins[i] ? 5 : 1;
        if (credit >= price) begin
          done    = 1;
          e.used  = 2'(i + 1);
          e.tmo   = 1'b0;
          e.item_ok = !wrong;
          e.wrong   = wrong;
          e.chg   = (credit - price > 15) ? 4'hF : CHG_W'(credit - price);
        end
      end
    end
    return e;
  endfunction

  // Drives one request, collects what the DUT did; expected result is pushed
  // to the scoreboard at request time and popped when the response appears.
  task automatic do_txn(input logic item, input logic [1:0] n, input logic [2:0] coins,
                        output rsp_t e, output obs_t o);
    int s_sa, s_sb, s_p1, s_p5, s_m, s_r;
    exp_q.push_back(model(item, n, coins, vendor_wrong));
    o.got = 0; o.rsp = 'x; o.hold = 'x;
    for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
    s_sa = sel_a_tot; s_sb = sel_b_tot; s_p1 = p1_tot; s_p5 = p5_tot;
    s_m = multi_tot; s_r = rsp_tot;
    bus.req_valid = 1'b1; bus.req_item = item; bus.req_ncoins = n; bus.req_coins = coins;
    @(negedge clk);
    bus.req_valid = 1'b0;
    o.rdy_busy = bus.req_ready;
    for (int i = 0; i < 200; i++) begin
      if (bus.rsp_valid) begin
        o.got = 1;
        o.rsp = {bus.rsp_item_ok, bus.rsp_wrong_item, bus.rsp_change,
                 bus.rsp_coins_used, bus.rsp_timeout};
        o.rdy_at_rsp = bus.req_ready;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    o.rdy_after   = bus.req_ready;
    o.valid_after = bus.rsp_valid;
    @(negedge clk);
    o.hold = {bus.rsp_item_ok, bus.rsp_wrong_item, bus.rsp_change,
              bus.rsp_coins_used, bus.rsp_timeout};
    o.sel_a = sel_a_tot - s_sa; o.sel_b = sel_b_tot - s_sb;
    o.p1 = p1_tot - s_p1; o.p5 = p5_tot - s_p5;
    o.multi = multi_tot - s_m; o.rsps = rsp_tot - s_r;
    o.lat = rsp_cyc - last_pulse_cyc;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_item = 1'b0; bus.req_ncoins = '0; bus.req_coins = '0;
    #2;
    checks++;
    if ({bus.sel_A, bus.sel_B, bus.p_1, bus.p_5, bus.rsp_valid, bus.rsp_item_ok,
         bus.rsp_wrong_item, bus.rsp_change, bus.rsp_coins_used, bus.rsp_timeout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", {bus.sel_A, bus.sel_B, bus.p_1, bus.p_5,
               bus.rsp_valid, bus.rsp_item_ok, bus.rsp_wrong_item, bus.rsp_change,
               bus.rsp_coins_used, bus.rsp_timeout});
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b want=1", bus.req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL idle_ready got=%b want=1", bus.req_ready);
    end
  endtask

  task automatic test_basic();
    rsp_t e; obs_t o;
    do_txn(ITEM_A, 2'd2, 3'b000, e, o);
    checks++;
    if (o.rsp !== e) begin failures++; $display("FAIL basic_rsp got=%h want=%h", o.rsp, e); end
    checks++;
    if (o.sel_a !== 1 || o.sel_b !== 0) begin
      failures++; $display("FAIL basic_sel got=%0d/%0d want=1/0", o.sel_a, o.sel_b);
    end
    checks++;
    if (o.p1 !== 2 || o.p5 !== 0) begin
      failures++; $display("FAIL basic_coins got=%0d/%0d want=2/0", o.p1, o.p5);
    end
    checks++;
    if (o.multi !== 0) begin failures++; $display("FAIL basic_onehot got=%0d want=0", o.multi); end
    checks++;
    if (o.rdy_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_ready got=%b want=0", o.rdy_busy); end
  endtask

  task automatic test_change();
    rsp_t e; obs_t o;
    do_txn(ITEM_A, 2'd1, 3'b001, e, o);
    checks++;
    if (o.rsp !== e) begin failures++; $display("FAIL change_rsp got=%h want=%h", o.rsp, e); end
    checks++;
    if (o.p5 !== 1 || o.p1 !== 0) begin
      failures++; $display("FAIL change_coins got=%0d/%0d want=1/0", o.p5, o.p1);
    end
    checks++;
    if (o.hold !== e) begin failures++; $display("FAIL change_hold got=%h want=%h", o.hold, e); end
    checks++;
    if (o.rsps !== 1 || o.valid_after !== 1'b0) begin
      failures++; $display("FAIL change_strobe got=%0d/%b want=1/0", o.rsps, o.valid_after);
    end
    checks++;
    if (o.rdy_at_rsp !== 1'b0 || o.rdy_after !== 1'b1) begin
      failures++; $display("FAIL change_ready got=%b%b want=01", o.rdy_at_rsp, o.rdy_after);
    end
  endtask

  task automatic test_item_b();
    rsp_t e; obs_t o;
    do_txn(ITEM_B, 2'd2, 3'b010, e, o);
    checks++;
    if (o.rsp !== e) begin failures++; $display("FAIL b15_rsp got=%h want=%h", o.rsp, e); end
    checks++;
    if (o.sel_b !== 1 || o.sel_a !== 0) begin
      failures++; $display("FAIL b15_sel got=%0d/%0d want=1/0", o.sel_b, o.sel_a);
    end
    do_txn(ITEM_B, 2'd3, 3'b000, e, o);
    checks++;
    if (o.rsp !== e) begin failures++; $display("FAIL b111_rsp got=%h want=%h", o.rsp, e); end
    checks++;
    if (o.p1 !== 3) begin failures++; $display("FAIL b111_coins got=%0d want=3", o.p1); end
  endtask

  task automatic test_early_dispense();
    rsp_t e; obs_t o;
    do_txn(ITEM_A, 2'd3, 3'b001, e, o);
    checks++;
    if (o.rsp !== e) begin failures++; $display("FAIL early_rsp got=%h want=%h", o.rsp, e); end
    checks++;
    if (o.p5 !== 1 || o.p1 !== 0) begin
      failures++; $display("FAIL early_coins got=%0d/%0d want=1/0", o.p5, o.p1);
    end
  endtask

  task automatic test_timeout();
    rsp_t e; obs_t o;
    do_txn(ITEM_A, 2'd1, 3'b000, e, o);
    checks++;
    if (o.rsp !== e) begin failures++; $display("FAIL timeout_rsp got=%h want=%h", o.rsp, e); end
    // last pulse -> GAP cycles -> WAIT for TIMEOUT cycles -> RESP
    checks++;
    if (o.lat !== GAP + 1 + TIMEOUT) begin
      failures++; $display("FAIL timeout_latency got=%0d want=%0d", o.lat, GAP + 1 + TIMEOUT);
    end
  endtask

  task automatic test_no_coins();
    rsp_t e; obs_t o;
    do_txn(ITEM_B, 2'd0, 3'b111, e, o);
    checks++;
    if (o.rsp !== e) begin failures++; $display("FAIL nocoin_rsp got=%h want=%h", o.rsp, e); end
    checks++;
    if (o.p1 + o.p5 !== 0 || o.lat !== GAP + 1 + TIMEOUT) begin
      failures++; $display("FAIL nocoin_seq got=%0d/%0d want=0/%0d", o.p1 + o.p5, o.lat, GAP + 1 + TIMEOUT);
    end
  endtask

  task automatic test_wrong_item();
    rsp_t e; obs_t o;
    vendor_wrong = 1'b1;
    do_txn(ITEM_A, 2'd1, 3'b001, e, o);
    vendor_wrong = 1'b0;
    checks++;
    if (o.rsp !== e) begin failures++; $display("FAIL wrong_rsp got=%h want=%h", o.rsp, e); end
  endtask

  task automatic test_reset_mid();
    rsp_t e; obs_t o;
    int   s_r;
    bit   seen;
    seen = 0;
    exp_q.push_back(model(ITEM_B, 2'd3, 3'b000, 1'b0));
    for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_item = ITEM_B; bus.req_ncoins = 2'd3; bus.req_coins = 3'b000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.p_1) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL midrst_coin got=0 want=1"); end
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    checks++;
    if ({bus.sel_A, bus.sel_B, bus.p_1, bus.p_5, bus.rsp_valid, bus.rsp_item_ok,
         bus.rsp_wrong_item, bus.rsp_change, bus.rsp_coins_used, bus.rsp_timeout,
         bus.req_ready} !== 15'd1) begin
      failures++;
      $display("FAIL midrst_outputs got=%b want=000000000000001", {bus.sel_A, bus.sel_B,
               bus.p_1, bus.p_5, bus.rsp_valid, bus.rsp_item_ok, bus.rsp_wrong_item,
               bus.rsp_change, bus.rsp_coins_used, bus.rsp_timeout, bus.req_ready});
    end
    s_r = rsp_tot;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (rsp_tot - s_r !== 0) begin
      failures++; $display("FAIL midrst_no_rsp got=%0d want=0", rsp_tot - s_r);
    end
    do_txn(ITEM_A, 2'd2, 3'b000, e, o);
    checks++;
    if (o.rsp !== e) begin failures++; $display("FAIL midrst_after got=%h want=%h", o.rsp, e); end
  endtask

  task automatic test_back_to_back();
    rsp_t e; obs_t o;
    do_txn(ITEM_B, 2'd1, 3'b001, e, o);
    checks++;
    if (o.rsp !== e) begin failures++; $display("FAIL b2b_first got=%h want=%h", o.rsp, e); end
    do_txn(ITEM_A, 2'd2, 3'b010, e, o);
    checks++;
    if (o.rsp !== e) begin failures++; $display("FAIL b2b_second got=%h want=%h", o.rsp, e); end
    checks++;
    if (o.sel_a !== 1 || o.p1 !== 1 || o.p5 !== 1) begin
      failures++; $display("FAIL b2b_pulses got=%0d/%0d/%0d want=1/1/1", o.sel_a, o.p1, o.p5);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_change();
    test_item_b();
    test_early_dispense();
    test_timeout();
    test_no_coins();
    test_wrong_item();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/vendo_buyer.md
Name: vendo_buyer

Overview:
- Transaction initiator for the vending FSM. Drives the FSM's selection and coin inputs, observes its disp_A/disp_B/change outputs, and returns one response per purchase.
- Sits between a test/host controller and the vending block. Each request is converted into a legal pulse sequence: select, then coins.
- Response reports item correctness, change units received, coins actually inserted, and timeout.

Parameters:
- GAP, 1, idle cycles after every select or coin pulse (minimum 0).
- TIMEOUT, 16, cycles to wait for any disp/change after the last coin.
- CHG_W, 4, width of the change counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  purchase request.
- req_ready  out  1  high only in IDLE.
- req_item  in  1  0 = item A, 1 = item B.
- req_ncoins  in  2  number of coins to insert, 0..3.
- req_coins  in  3  bit i is the coin i type: 0 = 1-peso, 1 = 5-peso. Coin 0 is inserted first.
- sel_A  out  1  one-cycle select pulse to vendor.
- sel_B  out  1  one-cycle select pulse to vendor.
- p_1  out  1  one-cycle 1-peso pulse.
- p_5  out  1  one-cycle 5-peso pulse.
- disp_A  in  1  from vendor.
- disp_B  in  1  from vendor.
- change  in  1  from vendor; one cycle high per peso returned.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_item_ok  out  1  requested item was dispensed.
- rsp_wrong_item  out  1  the other item was dispensed.
- rsp_change  out  CHG_W  count of change-high cycles.
- rsp_coins_used  out  2  coins actually pulsed.
- rsp_timeout  out  1  no vendor output within TIMEOUT.

Behaviour:
- Reset:
  - All outputs are 0, except req_ready = 1.
  - State = IDLE; counters and latched request are cleared.
  - Reset mid-transaction aborts immediately; no response is issued.
- All outputs are registered. Pulses last exactly one cycle, and at most one of sel_A/sel_B/p_1/p_5 is high in any cycle.
- IDLE:
  - On req_valid & req_ready, latch item, ncoins and coins.
  - Clear the coin index, result flags and counters, then go to SEL.
- SEL: drive sel_A (item 0) or sel_B (item 1) for 1 cycle, then go to GAP.
- GAP:
  - Hold all pulses low for GAP cycles, monitoring the vendor outputs.
  - Any of disp_A, disp_B or change high → go to COUNT.
  - GAP expires with index < ncoins → go to COIN.
  - GAP expires otherwise → go to WAIT.
  - GAP = 0 means advance on the next cycle.
- COIN:
  - Drive p_5 if req_coins[index] = 1, else p_1, for 1 cycle.
  - Increment index (which is coins_used), then go to GAP.
- WAIT:
  - Count cycles. Any disp_A, disp_B or change high → go to COUNT.
  - Count reaches TIMEOUT → set timeout and go to RESP.
- COUNT:
  - Evaluated on the entry cycle and on every subsequent cycle.
  - disp_A/disp_B matching the requested item sets item_ok; the non-matching one sets wrong_item.
  - change = 1 increments the change counter, saturating at all-ones.
  - First cycle with change = 0 and no disp → go to RESP. A dispense with no change therefore ends the transaction one cycle later.
- RESP:
  - rsp_valid = 1 for one cycle, with all rsp_* fields valid in that cycle.
  - Return to IDLE; req_ready rises the next cycle.
  - rsp_* fields hold their values until the next request is accepted.
- Early dispense: if the vendor responds before all coins are pulsed, the remaining coins are never pulsed, and rsp_coins_used reports the actual count.
- ncoins = 0: select only, then WAIT, ending in timeout.
- Vendor outputs are sampled only in GAP, WAIT and COUNT; activity in other states is ignored.
- Pricing:
  - A costs 2; B costs 3. Change equals tendered minus price.
  - Example: A paid with one 5-peso coin → 3 change cycles.

Decomposition:
- Shared package vendo_pkg:
  - State encoding localparams (IDLE, SEL, GAP, COIN, WAIT, COUNT, RESP).
  - ITEM_A/ITEM_B and COIN_1/COIN_5 constants.
  - PRICE_A = 2 and PRICE_B = 3, for benches.
- One natural sub-module, vendo_buyer_tmr: a loadable down-counter shared by the GAP and WAIT durations. Everything else stays in one FSM module.

Test Plan:
- Item A, ncoins = 2, coins {1,1}, GAP = 1 → sel_A then two p_1 pulses; rsp_item_ok = 1, change = 0, coins_used = 2, timeout = 0.
- Item A, ncoins = 1, coins {5} → rsp_item_ok = 1, rsp_change = 3, coins_used = 1.
- Item B, ncoins = 2, coins {1,5} → rsp_item_ok = 1, rsp_change = 3, coins_used = 2. Item B, coins {1,1,1} → change = 0, coins_used = 3.
- Item A, coins {5,1,1} → dispense after the first coin; no further p_1 pulses; coins_used = 1, change = 3.
- Item A, ncoins = 1, coins {1}, TIMEOUT = 16 → rsp_valid exactly 16 cycles after entering WAIT; timeout = 1, item_ok = 0, change = 0.
- Assert rst during COIN of a 3-coin request → all outputs 0 asynchronously, req_ready = 1, no rsp_valid. A new request then completes normally.
